matrix_loader: RTL

Byte-serial front end for the 3x3 `matrix` multiplier. It accepts a stream of 8-bit elements over a valid/ready handshake and assembles them into the 18 parallel operand registers (A00..A22, then B00..B22, row-major). It then pulses `Load` to the multiplier, waits a fixed compute latency, and signals `Done`. It sits between the board-level byte source (UART/switch logic) and `matrix`.

---
 rtl/matrix_pkg.sv | 8 +
 rtl/matrix_elem_bank.sv | 27 ++
 rtl/matrix_loader.sv | 101 ++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// matrix_pkg: shared element width, element counts and loader state encoding
package matrix_pkg;
    localparam int ELEM_W = 8;
    localparam int N      = 3;
    localparam int NELEM  = N * N;
    localparam int NTOTAL = 2 * NELEM;
    typedef enum logic [2:0] {FILL_A, FILL_B, LOAD, WAIT, DONE} state_t;
endpackage

// File: rtl/matrix_elem_bank.sv
// matrix_elem_bank: 18-entry operand register bank written one element at a time
//   i_clk, i_rst_n : clock, async active-low clear
//   i_we, i_idx    : write enable and element index (0..17)
//   i_data         : element written at i_idx
//   o_regs         : all 18 elements in parallel (A row-major, then B row-major)
module matrix_elem_bank
    import matrix_pkg::*;
#(
    parameter int W = ELEM_W
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_we,
    input  logic [4:0]   i_idx,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_regs [NTOTAL]
);
    logic [W-1:0] r_regs [NTOTAL];
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NTOTAL; i++) r_regs[i] <= '0;
        end else if (i_we && i_idx < 5'(NTOTAL)) begin
            r_regs[i_idx] <= i_data;
        end
    end
    assign o_regs = r_regs;
endmodule

// File: rtl/matrix_loader.sv
// matrix_loader: byte-serial loader that fills A/B operands, strobes Load and flags Done
//   clk, Reset          : clock, async active-low reset
//   Ain, Ain_valid      : element stream in; Ain_ready high only while filling
//   Abort               : synchronous restart of the fill (operands retained)
//   A00..A22, B00..B22  : operand registers, row-major
//   Load, Done, Cnt     : load strobe, result-valid pulse, elements accepted this frame
module matrix_loader
    import matrix_pkg::*;
#(
    parameter int W            = ELEM_W,
    parameter int LOAD_CYCLES  = 1,
    parameter int MULT_LATENCY = 2
) (
    input  logic         clk,
    input  logic         Reset,
    input  logic [W-1:0] Ain,
    input  logic         Ain_valid,
    output logic         Ain_ready,
    input  logic         Abort,
    output logic [W-1:0] A00, A01, A02, A10, A11, A12, A20, A21, A22,
    output logic [W-1:0] B00, B01, B02, B10, B11, B12, B20, B21, B22,
    output logic         Load,
    output logic         Done,
    output logic [4:0]   Cnt
);
    localparam logic [3:0] LC_LAST = 4'(LOAD_CYCLES - 1);
    localparam logic [3:0] ML_LAST = 4'(MULT_LATENCY - 1);
    state_t       r_state;
    logic [4:0]   r_cnt;
    logic [3:0]   r_tmr;
    logic         r_load, r_done;
    logic         w_xfer;
    logic [W-1:0] w_regs [NTOTAL];
    assign Ain_ready = (r_state == FILL_A) || (r_state == FILL_B);
    assign w_xfer    = Ain_valid && Ain_ready && !Abort;
    matrix_elem_bank #(.W(W)) u_bank (
        .i_clk   (clk),
        .i_rst_n (Reset),
        .i_we    (w_xfer),
        .i_idx   (r_cnt),
        .i_data  (Ain),
        .o_regs  (w_regs)
    );
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= FILL_A;
            r_cnt   <= '0;
            r_tmr   <= '0;
            r_load  <= 1'b0;
            r_done  <= 1'b0;
        end else if (Abort) begin
            r_state <= FILL_A;
            r_cnt   <= '0;
            r_tmr   <= '0;
            r_load  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                FILL_A, FILL_B: if (w_xfer) begin
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'(NELEM - 1)) r_state <= FILL_B;
                    if (r_cnt == 5'(NTOTAL - 1)) begin
                        r_state <= LOAD;
                        r_load  <= 1'b1;
                        r_tmr   <= '0;
                    end
                end
                LOAD: if (r_tmr == LC_LAST) begin
                    // zero multiplier latency skips WAIT entirely
                    r_load  <= 1'b0;
                    r_tmr   <= '0;
                    r_state <= (MULT_LATENCY == 0) ? DONE : WAIT;
                    r_done  <= (MULT_LATENCY == 0);
                end else begin
                    r_tmr <= r_tmr + 4'd1;
                end
                WAIT: if (r_tmr == ML_LAST) begin
                    r_state <= DONE;
                    r_done  <= 1'b1;
                end else begin
                    r_tmr <= r_tmr + 4'd1;
                end
                DONE: begin
                    r_state <= FILL_A;
                    r_done  <= 1'b0;
                    r_cnt   <= '0;
                end
                default: r_state <= FILL_A;
            endcase
        end
    end
    assign Load = r_load;
    assign Done = r_done;
    assign Cnt  = r_cnt;
    assign {A00, A01, A02} = {w_regs[0],  w_regs[1],  w_regs[2]};
    assign {A10, A11, A12} = {w_regs[3],  w_regs[4],  w_regs[5]};
    assign {A20, A21, A22} = {w_regs[6],  w_regs[7],  w_regs[8]};
    assign {B00, B01, B02} = {w_regs[9],  w_regs[10], w_regs[11]};
    assign {B10, B11, B12} = {w_regs[12], w_regs[13], w_regs[14]};
    assign {B20, B21, B22} = {w_regs[15], w_regs[16], w_regs[17]};
endmodule
